aes_round_controller: RTL and testbench

- Parametrised round sequencer for the AES core. It replaces the fixed 10-round, decrypt-only controller.
- Supports AES-128/192/256 (10/12/14 rounds) and encrypt or decrypt mode.
- Uses an explicit start/done handshake, with abort and reserved-key-length rejection.
- Sits between the core's top-level handshake and the round datapath / key-expansion unit. It drives the round index, the key-schedule index and the phase strobes.

---
 rtl/aes_pkg.sv | 32 +++
 rtl/aes_round_counter.sv | 36 +++
 rtl/aes_round_controller.sv | 130 +++++++++++++
 tb/tb_aes_round_controller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencer: FSM states,
// key-length encodings and the key-length to round-count mapping.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ROUND,
    ST_FINAL,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    KEY128   = 2'b00,
    KEY192   = 2'b01,
    KEY256   = 2'b10,
    KEY_RSVD = 2'b11
  } key_len_e;

  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_192 = 12;
  localparam int unsigned NR_256 = 14;

  function automatic int unsigned nr_for(input key_len_e key_len);
    case (key_len)
      KEY192:  return NR_192;
      KEY256:  return NR_256;
      default: return NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Round up-counter with load/clear/advance control and the round-key index
// mirror (counts up when encrypting, down from Nr when decrypting).
module aes_round_counter #(
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load,
  input  logic          load_dec,
  input  logic [RW-1:0] load_nr,
  input  logic          advance,
  input  logic          count_down,
  output logic [RW-1:0] round_num,
  output logic [RW-1:0] key_idx
);

  // NOTE: sequential state uses non-blocking assignments with an async
  // active-low reset, so every flop sees pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_num <= '0;
      key_idx   <= '0;
    end else if (clear) begin
      round_num <= '0;
      key_idx   <= '0;
    end else if (load) begin
      round_num <= '0;
      key_idx   <= load_dec ? load_nr : '0;
    end else if (advance) begin
      round_num <= round_num + RW'(1);
      key_idx   <= count_down ? key_idx - RW'(1) : key_idx + RW'(1);
    end
  end

endmodule

// File: rtl/aes_round_controller.sv
// AES-128/192/256 round sequencer with start/done handshake, abort and
// reserved-key rejection. Optional stall input enabled by AES_ROUND_STALL_EN.
module aes_round_controller
  import aes_pkg::*;
#(
  parameter int unsigned NR_MAX = 14,
  parameter int          RW     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic          decrypt_i,
  input  logic [1:0]    key_len_i,
  input  logic          abort_i,
`ifdef AES_ROUND_STALL_EN
  input  logic          hold_i,
`endif
  output logic          ready_o,
  output logic          busy_o,
  output logic [RW-1:0] round_num_o,
  output logic [RW-1:0] key_idx_o,
  output logic          begin_round_o,
  output logic          first_round_o,
  output logic          last_round_o,
  output logic          rkey_en_o,
  output logic          decrypt_o,
  output logic          done_o,
  output logic          err_o
);

  state_e        state_q, state_d;
  logic [RW-1:0] nr_q, nr_d;
  logic          dec_q, err_q, err_d, capture;
  logic          cnt_clear, cnt_load, cnt_adv;
  logic          hold, active;
  int unsigned   nr_raw;

`ifdef AES_ROUND_STALL_EN
  assign hold = hold_i;
`else
  assign hold = 1'b0;
`endif

  assign nr_raw = nr_for(key_len_e'(key_len_i));
  assign nr_d   = (nr_raw > NR_MAX) ? RW'(NR_MAX) : RW'(nr_raw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      nr_q    <= RW'(NR_128);
      dec_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (capture) begin
        nr_q  <= nr_d;
        dec_q <= decrypt_i;
      end
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    cnt_clear = 1'b0;
    cnt_load  = 1'b0;
    cnt_adv   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (key_len_e'(key_len_i) == KEY_RSVD) begin
            err_d = 1'b1;
          end else begin
            capture  = 1'b1;
            cnt_load = 1'b1;
            state_d  = ST_INIT;
          end
        end
      end
      ST_INIT, ST_ROUND, ST_FINAL: begin
        // Abort wins over hold; a held cycle changes nothing.
        if (abort_i) begin
          state_d   = ST_IDLE;
          cnt_clear = 1'b1;
        end else if (!hold) begin
          if (state_q == ST_INIT) begin
            state_d = ST_ROUND;
            cnt_adv = 1'b1;
          end else if (state_q == ST_ROUND) begin
            cnt_adv = 1'b1;
            if (round_num_o == nr_q - RW'(1)) state_d = ST_FINAL;
          end else begin
            state_d   = ST_DONE;
            cnt_clear = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  aes_round_counter #(.RW(RW)) u_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (cnt_clear),
    .load       (cnt_load),
    .load_dec   (decrypt_i),
    .load_nr    (nr_d),
    .advance    (cnt_adv),
    .count_down (dec_q),
    .round_num  (round_num_o),
    .key_idx    (key_idx_o)
  );

  assign active        = (state_q == ST_INIT) || (state_q == ST_ROUND) || (state_q == ST_FINAL);
  assign ready_o       = (state_q == ST_IDLE);
  assign busy_o        = ~ready_o;
  assign begin_round_o = (state_q == ST_INIT);
  assign first_round_o = (state_q == ST_ROUND) && (round_num_o == RW'(1));
  assign last_round_o  = (state_q == ST_FINAL);
  assign rkey_en_o     = active && !hold;
  assign decrypt_o     = dec_q;
  assign done_o        = (state_q == ST_DONE);
  assign err_o         = err_q;

endmodule

// File: tb/tb_aes_round_controller.sv
// Randomized self-checking bench for aes_round_controller; expected outputs
// come from a per-cycle model of the round schedule.
module tb_aes_round_controller;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          decrypt_i = 1'b0;
  logic [1:0]    key_len_i = 2'b00;
  logic          abort_i = 1'b0;
`ifdef AES_ROUND_STALL_EN
  logic          hold_i = 1'b0;
`endif
  logic          ready_o, busy_o, begin_round_o, first_round_o, last_round_o;
  logic          rkey_en_o, decrypt_o, done_o, err_o;
  logic [RW-1:0] round_num_o, key_idx_o;

  int   errors = 0;
  int   checks = 0;
  logic model_dec = 1'b0;

  aes_round_controller #(.NR_MAX(14), .RW(RW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start_i),
    .decrypt_i     (decrypt_i),
    .key_len_i     (key_len_i),
    .abort_i       (abort_i),
`ifdef AES_ROUND_STALL_EN
    .hold_i        (hold_i),
`endif
    .ready_o       (ready_o),
    .busy_o        (busy_o),
    .round_num_o   (round_num_o),
    .key_idx_o     (key_idx_o),
    .begin_round_o (begin_round_o),
    .first_round_o (first_round_o),
    .last_round_o  (last_round_o),
    .rkey_en_o     (rkey_en_o),
    .decrypt_o     (decrypt_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag, input logic ready, input int rnd, input int key,
                               input logic b, input logic f, input logic l, input logic rk,
                               input logic dn);
    check({tag, ".ready"}, 32'(ready_o), 32'(ready));
    check({tag, ".busy"},  32'(busy_o), 32'(!ready));
    check({tag, ".round"}, 32'(round_num_o), 32'(rnd));
    check({tag, ".key"},   32'(key_idx_o), 32'(key));
    check({tag, ".begin"}, 32'(begin_round_o), 32'(b));
    check({tag, ".first"}, 32'(first_round_o), 32'(f));
    check({tag, ".last"},  32'(last_round_o), 32'(l));
    check({tag, ".rkey"},  32'(rkey_en_o), 32'(rk));
    check({tag, ".done"},  32'(done_o), 32'(dn));
    check({tag, ".dec"},   32'(decrypt_o), 32'(model_dec));
  endtask

  task automatic check_idle(input string tag);
    check_outputs(tag, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Drives one accepted request from a negedge and follows it cycle by cycle.
  // The model tracks the current round r; each unheld cycle moves r up by one
  // until Nr, then one done cycle, then idle.
  task automatic run_op(input logic [1:0] kl, input logic dec, input int abort_r,
                        input int hold_r, input int hold_n, input logic keep_start);
    int nr;
    int r;
    int k;
    int used;
    bit in_done;
    bit held;
    bit ab;
    nr = 10 + 2 * int'(kl);
    r = 0; k = 0; used = 0; in_done = 0;
    start_i = 1'b1; key_len_i = kl; decrypt_i = dec;
    @(negedge clk);
    if (!keep_start) start_i = 1'b0;
    abort_i = 1'b0;
    model_dec = dec;
    forever begin
      k++;
      if (k > 100) begin
        check("op_timeout", 32'(k), 32'(0));
        return;
      end
      held = !in_done && (r == hold_r) && (used < hold_n);
      ab   = !in_done && (r == abort_r);
      abort_i = ab;
`ifdef AES_ROUND_STALL_EN
      hold_i = held;
`endif
      #1;
      if (in_done) begin
        check_outputs("done_cyc", 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("done_latency", 32'(k), 32'(nr + 2 + used));
      end else begin
        check_outputs("op_cyc", 1'b0, r, dec ? nr - r : r, r == 0, r == 1, r == nr,
                      !held, 1'b0);
      end
      check("op_err", 32'(err_o), 32'(0));
      @(negedge clk);
      abort_i = 1'b0;
`ifdef AES_ROUND_STALL_EN
      hold_i = 1'b0;
`endif
      if (ab) begin
        check_idle("post_abort");
        return;
      end else if (in_done) begin
        check_idle("post_done");
        return;
      end else if (held) begin
        used++;
      end else if (r == nr) begin
        in_done = 1;
      end else begin
        r++;
      end
    end
  endtask

  task automatic err_op(input logic dec);
    start_i = 1'b1; key_len_i = 2'b11; decrypt_i = dec;
    @(negedge clk);
    start_i = 1'b0;
    check("rsvd.err", 32'(err_o), 32'(1));
    check_idle("rsvd");
    @(negedge clk);
    check("rsvd.err_clr", 32'(err_o), 32'(0));
    check_idle("rsvd_after");
  endtask

  initial begin
    int kl;
    int nr;
    int ab_r;
    int hd_r;
    int hd_n;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset.err", 32'(err_o), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b00, 1'b0, -1, -1, 0, 1'b0);
    run_op(2'b10, 1'b1, -1, -1, 0, 1'b0);
    err_op(1'b0);
    run_op(2'b01, 1'b0, 5, -1, 0, 1'b0);
    run_op(2'b00, 1'b1, -1, -1, 0, 1'b0);

    // Abort together with start in IDLE: the start is accepted.
    abort_i = 1'b1;
    run_op(2'b01, 1'b1, -1, -1, 0, 1'b0);

    // Start held high across a whole operation: re-accepted only once idle.
    run_op(2'b01, 1'b0, -1, -1, 0, 1'b1);
    @(negedge clk);
    check("restart.begin", 32'(begin_round_o), 32'(1));
    check("restart.round", 32'(round_num_o), 32'(0));
    start_i = 1'b0;
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check_idle("restart_abort");

`ifdef AES_ROUND_STALL_EN
    run_op(2'b00, 1'b0, -1, 4, 3, 1'b0);
`endif

    for (int i = 0; i < 24; i++) begin
      kl = $urandom_range(0, 3);
      if (kl == 3) begin
        err_op(1'($urandom_range(0, 1)));
      end else begin
        nr   = 10 + 2 * kl;
        ab_r = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nr)) : -1;
        hd_r = -1;
        hd_n = 0;
`ifdef AES_ROUND_STALL_EN
        if ($urandom_range(0, 1) == 1) begin
          hd_r = $urandom_range(0, nr);
          hd_n = $urandom_range(1, 4);
        end
`endif
        run_op(2'(kl), 1'($urandom_range(0, 1)), ab_r, hd_r, hd_n, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
